// File: rtl/vco_readout_dec.sv
// Ring-VCO quantiser readout: per-phase synchroniser, toggle popcount per sample,
// and a decimating saturating accumulator with sticky overflow.
module vco_readout_dec #(
  parameter int unsigned NPH   = 5,
  parameter int unsigned SYNC  = 2,
  parameter int unsigned CW    = $clog2(NPH + 1),
  parameter int unsigned DEC_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [NPH-1:0]   vco,
  input  logic [DEC_W-1:0] dec_ratio,
  output logic [CW-1:0]    qz,
  output logic             qz_vld,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_vld,
  output logic             ovf
);

  localparam int unsigned WCW = $clog2(SYNC + 1);
  localparam int unsigned SW  = ACC_W + 1;
  localparam int unsigned CNW = DEC_W + 1;

  typedef enum logic {WARM, RUN} state_t;

  state_t           state, state_nxt;
  logic [WCW-1:0]   wcnt, wcnt_nxt;
  logic             qz_vld_nxt;

  logic [NPH-1:0]   sync_q [SYNC];
  logic [NPH-1:0]   dly_q;
  logic [NPH-1:0]   edge_c;
  logic [CW-1:0]    pop_c;

  logic [ACC_W-1:0] acc;
  logic [DEC_W-1:0] cnt;
  logic [DEC_W-1:0] r_q;
  logic [DEC_W-1:0] r_eff_c;
  logic [SW-1:0]    sum_c;
  logic [ACC_W-1:0] sat_c;
  logic [CNW-1:0]   cnt_inc_c;
  logic             last_c;

  // Synchroniser chain plus one-cycle delay; shifts regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(SYNC); k++) sync_q[k] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= vco;
      for (int k = 1; k < int'(SYNC); k++) sync_q[k] <= sync_q[k-1];
      dly_q <= sync_q[SYNC-1];
    end
  end

  assign edge_c = sync_q[SYNC-1] ^ dly_q;

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(NPH); i++) pop_c = pop_c + CW'(edge_c[i]);
  end

  // Warm-up FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WARM;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: stay in WARM for SYNC+1 edges so reset-zero flops cannot leak toggles.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (state == WARM) begin
      if (wcnt == WCW'(SYNC)) begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end else begin
        wcnt_nxt = wcnt + WCW'(1);
      end
    end
  end

  // Output decode.
  always_comb begin
    qz_vld_nxt = 1'b0;
    if (state == RUN) qz_vld_nxt = en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qz     <= '0;
      qz_vld <= 1'b0;
    end else begin
      qz     <= en ? pop_c : '0;
      qz_vld <= qz_vld_nxt;
    end
  end

  // Window ratio is latched at window start; mid-window changes are ignored.
  always_comb begin
    r_eff_c = r_q;
    if (cnt == '0) r_eff_c = (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;
  end

  assign sum_c     = {1'b0, acc} + SW'(qz);
  assign sat_c     = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
  assign cnt_inc_c = {1'b0, cnt} + CNW'(1);
  assign last_c    = (cnt_inc_c == {1'b0, r_eff_c});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      r_q     <= '0;
      acc_out <= '0;
      acc_vld <= 1'b0;
      ovf     <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      acc_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      acc_vld <= 1'b0;
      if (qz_vld) begin
        if (cnt == '0) r_q <= r_eff_c;
        if (sum_c[ACC_W]) ovf <= 1'b1;
        if (last_c) begin
          acc_out <= sat_c;
          acc_vld <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sat_c;
          cnt <= cnt_inc_c[DEC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_vco_readout_dec.sv
// Bench for vco_readout_dec: directed and random stimulus against a sample-history
// reference model, with a default instance and a narrow-accumulator instance.
module tb_vco_readout_dec;

  localparam int NPH   = 5;
  localparam int SYNC  = 2;
  localparam int CW    = 3;
  localparam int DEC_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [NPH-1:0]   vco;
  logic [DEC_W-1:0] dec_ratio;

  logic [CW-1:0] qz_a, qz_b;
  logic          qv_a, qv_b;
  logic [15:0]   out_a;
  logic [3:0]    out_b;
  logic          av_a, av_b, ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vco_readout_dec u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .vco(vco), .dec_ratio(dec_ratio),
    .qz(qz_a), .qz_vld(qv_a), .acc_out(out_a), .acc_vld(av_a), .ovf(ovf_a)
  );

  vco_readout_dec #(.ACC_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .vco(vco), .dec_ratio(dec_ratio),
    .qz(qz_b), .qz_vld(qv_b), .acc_out(out_b), .acc_vld(av_b), .ovf(ovf_b)
  );

  // Reference model: history of captured tap words and per-instance window state.
  logic [NPH-1:0] hist[$];
  int ecnt;
  int m_qz, m_qv;
  int m_acc[2], m_cnt[2], m_r[2], m_out[2], m_avld[2], m_ovf[2];
  int maxv[2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    repeat (SYNC + 2) hist.push_back('0);
    ecnt = 0;
    m_qz = 0;
    m_qv = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_r[k] = 0; m_out[k] = 0; m_avld[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // One rising edge with the currently driven inputs.
  task automatic model_edge();
    int s;
    for (int k = 0; k < 2; k++) begin
      m_avld[k] = 0;
      if (clr) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      end else if (m_qv != 0) begin
        if (m_cnt[k] == 0) m_r[k] = (dec_ratio == 0) ? 1 : int'(dec_ratio);
        s = m_acc[k] + m_qz;
        if (s > maxv[k]) begin
          s = maxv[k];
          m_ovf[k] = 1;
        end
        m_cnt[k]++;
        if (m_cnt[k] == m_r[k]) begin
          m_out[k] = s; m_avld[k] = 1; m_acc[k] = 0; m_cnt[k] = 0;
        end else begin
          m_acc[k] = s;
        end
      end
    end
    hist.push_back(vco);
    void'(hist.pop_front());
    ecnt++;
    m_qz = en ? $countones(hist[1] ^ hist[0]) : 0;
    m_qv = (ecnt >= SYNC + 2 && en) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("qz", 32'(qz_a), 32'(m_qz));
    chk("qz_vld", 32'(qv_a), 32'(m_qv));
    chk("qz_sat_inst", 32'(qz_b), 32'(m_qz));
    chk("acc_out", 32'(out_a), 32'(m_out[0]));
    chk("acc_vld", 32'(av_a), 32'(m_avld[0]));
    chk("ovf", 32'(ovf_a), 32'(m_ovf[0]));
    chk("acc_out_w4", 32'(out_b), 32'(m_out[1]));
    chk("acc_vld_w4", 32'(av_b), 32'(m_avld[1]));
    chk("ovf_w4", 32'(ovf_b), 32'(m_ovf[1]));
  endtask

  task automatic cyc(input logic [NPH-1:0] v, input logic e, input logic c, input int dr);
    vco = v;
    en = e;
    clr = c;
    dec_ratio = DEC_W'(dr);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_qz"}, 32'(qz_a), 0);
    chk({tag, "_qz_vld"}, 32'(qv_a), 0);
    chk({tag, "_acc_out"}, 32'(out_a), 0);
    chk({tag, "_acc_vld"}, 32'(av_a), 0);
    chk({tag, "_ovf"}, 32'(ovf_b), 0);
  endtask

  initial begin
    logic [NPH-1:0] cur;
    int vld_seen;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; vco = '0; dec_ratio = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Constant taps through warm-up: qz_vld low for three edges, no accumulation.
    cur = 5'b10110;
    for (int i = 0; i < 3; i++) begin
      cyc(cur, 1'b1, 1'b0, 4);
      chk("warm_qz_vld", 32'(qv_a), 0);
    end
    for (int i = 0; i < 6; i++) cyc(cur, 1'b1, 1'b0, 4);
    chk("const_qz", 32'(qz_a), 0);
    chk("const_qz_vld", 32'(qv_a), 1);

    // Single tap toggle.
    cur[2] = ~cur[2];
    for (int i = 0; i < 5; i++) cyc(cur, 1'b1, 1'b0, 4);

    // All phases toggle every cycle: qz=5, windows of 4 then of 1.
    for (int i = 0; i < 12; i++) begin
      cur = ~cur;
      cyc(cur, 1'b1, 1'b0, 4);
    end
    chk("inv_qz", 32'(qz_a), 5);
    chk("sat_ovf", 32'(ovf_b), 1);
    for (int i = 0; i < 6; i++) begin
      cur = ~cur;
      cyc(cur, 1'b1, 1'b0, 0);
    end
    chk("dec0_acc_out", 32'(out_a), 5);
    chk("dec0_acc_vld", 32'(av_a), 1);

    // Clear on a window's last sample suppresses the strobe.
    cur = ~cur; cyc(cur, 1'b1, 1'b1, 4);
    chk("clr_ovf", 32'(ovf_b), 0);
    for (int i = 0; i < 3; i++) begin
      cur = ~cur; cyc(cur, 1'b1, 1'b0, 4);
    end
    cur = ~cur; cyc(cur, 1'b1, 1'b1, 4);
    chk("clr_last_no_vld", 32'(av_a), 0);
    for (int i = 0; i < 6; i++) begin
      cur = ~cur; cyc(cur, 1'b1, 1'b0, 4);
    end

    // Asynchronous reset mid-window.
    cur = ~cur; cyc(cur, 1'b1, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cur = ~cur; cyc(cur, 1'b1, 1'b0, 4);
      if (i < 3) chk("rel_qz_vld", 32'(qv_a), 0);
    end

    // en gap of 3 cycles mid-window.
    for (int i = 0; i < 3; i++) begin
      cur = ~cur; cyc(cur, 1'b0, 1'b0, 4);
    end
    for (int i = 0; i < 8; i++) begin
      cur = ~cur; cyc(cur, 1'b1, 1'b0, 4);
      if (av_a) vld_seen++;
    end
    chk("gap_strobes", 32'(vld_seen), 2);

    // Random stimulus.
    for (int i = 0; i < 400; i++) begin
      cyc(NPH'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0),
          int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
